pdm_decimator: RTL and testbench

//  Receive end of the DAC link: converts the 1-bit sigma-delta stream from dac.dout

---
 rtl/synth_pkg.sv | 12 +
 rtl/cic_comb_stage.sv | 16 +
 rtl/pdm_decimator.sv | 47 ++++
 tb/tb_pdm_decimator.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: CIC decimator dimensions shared with clkdiv/dac.
package synth_pkg;
  localparam int CIC_N = 3;
  localparam int CIC_R = 512;
  localparam int OUT_W = 16;
  localparam int SAMPLE_DIV = 512;
  localparam int CNT_W = $clog2(CIC_R);
  localparam int ACC_W = CIC_N * CNT_W + 1;
  localparam int SHIFT = ACC_W - 1 - OUT_W;
  localparam int PRIME_W = $clog2(CIC_N + 1);
  typedef logic [ACC_W-1:0] acc_t;
endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one CIC comb, y = x - x delayed by one decimated sample.
module cic_comb_stage
  import synth_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  acc_t x,
  output acc_t y
);
  acc_t d;
  assign y = x - d;
  always_ff @(posedge clk)
    if (!rst) d <= '0;
    else if (en) d <= x;
endmodule

// File: rtl/pdm_decimator.sv
// pdm_decimator: 3rd-order CIC (R=512) turning a 1-bit PDM stream into 16-bit unsigned PCM.
module pdm_decimator
  import synth_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             din,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid
);
  acc_t i1, i2, i3, i1n, i2n, i3n, y_sh;
  logic [CIC_N:0][ACC_W-1:0] c;
  logic [CNT_W-1:0] cnt;
  logic [PRIME_W-1:0] prime;
  logic inst;
  assign i1n = i1 + acc_t'(din);
  assign i2n = i2 + i1n;
  assign i3n = i3 + i2n;
  assign inst = ce && cnt == CNT_W'(CIC_R - 1);
  assign c[0] = i3n;
  // Integrators wrap modulo 2^ACC_W; the combs cancel the wrap exactly.
  for (genvar k = 0; k < CIC_N; k++) begin : g_comb
    cic_comb_stage u_comb (.clk(clk), .rst(rst), .en(inst), .x(c[k]), .y(c[k+1]));
  end
  assign y_sh = c[CIC_N] >> SHIFT;
  always_ff @(posedge clk)
    if (!rst) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
      cnt <= '0;
      prime <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= inst && prime == PRIME_W'(CIC_N);
      if (ce) begin
        i1 <= i1n;
        i2 <= i2n;
        i3 <= i3n;
        cnt <= cnt + 1'b1;
      end
      if (inst && prime != PRIME_W'(CIC_N)) prime <= prime + 1'b1;
      if (inst && prime == PRIME_W'(CIC_N)) dout <= |y_sh[ACC_W-1:OUT_W] ? '1 : y_sh[OUT_W-1:0];
    end
endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: directed checks of priming, scaling, saturation, ce gating, reset and loopback.
module tb_pdm_decimator;
  logic clk = 1'b0, rst = 1'b0, ce = 1'b0, din = 1'b0;
  logic [15:0] dout;
  logic dout_valid;
  int total = 0, bad = 0;

  pdm_decimator dut (.clk(clk), .rst(rst), .ce(ce), .din(din), .dout(dout), .dout_valid(dout_valid));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; ce = 1'b1; din = 1'b0;
    step;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; ce = 1'b1; din = 1'b1;
    repeat (3) step;
    total++; if (dout !== 16'd0) begin bad++; $display("FAIL reset_dout got %0d want 0", dout); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", dout_valid); end
  endtask

  task automatic test_zero;
    int first = -1, strobes = 0;
    do_reset;
    for (int n = 1; n <= 3072; n++) begin
      din = 1'b0; ce = 1'b1;
      step;
      if (dout_valid) begin
        strobes++;
        if (first < 0) first = n;
        total++; if (dout !== 16'd0) begin bad++; $display("FAIL zero_dout edge=%0d got %0d want 0", n, dout); end
      end
    end
    total++; if (first != 2048) begin bad++; $display("FAIL zero_first_strobe got %0d want 2048", first); end
    total++; if (strobes != 3) begin bad++; $display("FAIL zero_strobes got %0d want 3", strobes); end
  endtask

  task automatic test_ones;
    int first = -1, last = -1, strobes = 0;
    do_reset;
    for (int n = 1; n <= 4096; n++) begin
      din = 1'b1; ce = 1'b1;
      step;
      if (dout_valid) begin
        strobes++;
        if (first < 0) first = n;
        total++; if (dout !== 16'd65535) begin bad++; $display("FAIL ones_dout edge=%0d got %0d want 65535", n, dout); end
        if (last > 0) begin
          total++; if (n - last != 512) begin bad++; $display("FAIL ones_period got %0d want 512", n - last); end
        end
        last = n;
      end
    end
    total++; if (first != 2048) begin bad++; $display("FAIL ones_first_strobe got %0d want 2048", first); end
    total++; if (strobes != 5) begin bad++; $display("FAIL ones_strobes got %0d want 5", strobes); end
  endtask

  task automatic test_alt;
    int strobes = 0;
    do_reset;
    for (int n = 1; n <= 4096; n++) begin
      din = n[0]; ce = 1'b1;
      step;
      if (dout_valid) begin
        strobes++;
        total++; if (dout !== 16'd32768) begin bad++; $display("FAIL alt_dout edge=%0d got %0d want 32768", n, dout); end
      end
    end
    total++; if (strobes != 5) begin bad++; $display("FAIL alt_strobes got %0d want 5", strobes); end
  endtask

  task automatic test_ce_toggle;
    int first = -1, last = -1, strobes = 0;
    logic prev = 1'b0;
    do_reset;
    for (int n = 1; n <= 7200; n++) begin
      din = 1'b1; ce = n[0];
      step;
      if (dout_valid && prev) begin
        total++; bad++; $display("FAIL ce_back_to_back edge=%0d got 2 strobes want 1", n);
      end
      prev = dout_valid;
      if (dout_valid) begin
        strobes++;
        if (first < 0) first = n;
        total++; if (dout !== 16'd65535) begin bad++; $display("FAIL ce_dout edge=%0d got %0d want 65535", n, dout); end
        if (last > 0) begin
          total++; if (n - last != 1024) begin bad++; $display("FAIL ce_period got %0d want 1024", n - last); end
        end
        last = n;
      end
    end
    total++; if (first != 4095) begin bad++; $display("FAIL ce_first_strobe got %0d want 4095", first); end
    total++; if (strobes != 4) begin bad++; $display("FAIL ce_strobes got %0d want 4", strobes); end
  endtask

  task automatic test_reset_mid;
    int early = 0;
    do_reset;
    for (int n = 1; n <= 2860; n++) begin
      din = 1'b1; ce = 1'b1;
      step;
    end
    total++; if (dout !== 16'd65535) begin bad++; $display("FAIL mid_pre_dout got %0d want 65535", dout); end
    rst = 1'b0;
    step;
    total++; if (dout !== 16'd0) begin bad++; $display("FAIL mid_rst_dout got %0d want 0", dout); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got %b want 0", dout_valid); end
    rst = 1'b1;
    for (int n = 1; n <= 2048; n++) begin
      din = 1'b1; ce = 1'b1;
      step;
      if (n < 2048 && dout_valid) early++;
      if (n == 2047) begin
        total++; if (dout !== 16'd0) begin bad++; $display("FAIL mid_prime_dout got %0d want 0", dout); end
      end
    end
    total++; if (early != 0) begin bad++; $display("FAIL mid_early_strobes got %0d want 0", early); end
    total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL mid_first_valid got %b want 1", dout_valid); end
    total++; if (dout !== 16'd65535) begin bad++; $display("FAIL mid_first_dout got %0d want 65535", dout); end
  endtask

  // First-order modulator standing in for dac with a 16384 input: density exactly 1/4.
  task automatic test_loopback;
    int unsigned acc = 0;
    int first = -1, last = -1, strobes = 0, dv;
    do_reset;
    for (int n = 1; n <= 2048 + 512 * 20; n++) begin
      acc += 16384;
      din = acc >= 65536;
      if (acc >= 65536) acc -= 65536;
      ce = 1'b1;
      step;
      if (dout_valid) begin
        strobes++;
        if (first < 0) first = n;
        dv = int'(dout);
        total++; if (dv < 16380 || dv > 16388) begin bad++; $display("FAIL loop_dout edge=%0d got %0d want 16384+/-4", n, dv); end
        if (last > 0) begin
          total++; if (n - last != 512) begin bad++; $display("FAIL loop_period got %0d want 512", n - last); end
        end
        last = n;
      end
    end
    total++; if (strobes != 21) begin bad++; $display("FAIL loop_strobes got %0d want 21", strobes); end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_ones;
    test_alt;
    test_ce_toggle;
    test_reset_mid;
    test_loopback;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
